// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution pipeline stages.
// Holds the MAC state encoding and the operand extension helper.
package conv_pkg;

    localparam int CONV_DATA_W = 4;
    localparam int CONV_ACC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } mac_state_e;

    // Extends the low w bits of v to 64 bits, sign- or zero-filled.
    function automatic logic [63:0] conv_ext(
        input logic [31:0] v,
        input int          w,
        input logic        sgn
    );
        logic        fill;
        logic [63:0] r;
        fill = sgn & v[5'(w - 1)];
        r    = {{32{fill}}, v};
        for (int i = 0; i < 32; i++) begin
            if (i >= w) r[i] = fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, LSB first.
// Signed mode subtracts on the multiplier MSB for two's-complement.
module seq_mult_core
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [2*DATA_W-1:0] prod
);

    localparam int   CW  = $clog2(DATA_W + 1);
    localparam logic SGN = (SIGNED != 0);

    mac_state_e          state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;

    logic [DATA_W:0] a_ext;
    logic [DATA_W:0] hi_ext;
    logic [DATA_W:0] addend;
    logic [DATA_W:0] sum;
    logic            last;

    always_comb begin
        a_ext  = {SGN & a_q[DATA_W-1], a_q};
        hi_ext = {SGN & hi_q[DATA_W-1], hi_q};
        last   = (cnt_q == CW'(1));
        addend = '0;
        if (lo_q[0]) begin
            addend = (SGN && last) ? (~a_ext + 1'b1) : a_ext;
        end
        // Extra bit keeps the sum exact, so the shift needs no fill.
        sum = hi_ext + addend;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = a;
                    lo_d  = b;
                    hi_d  = '0;
                    cnt_d = CW'(DATA_W);
                    if (a == '0 || b == '0) begin
                        prod_d  = '0;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                hi_d  = sum[DATA_W:1];
                lo_d  = {sum[0], lo_q[DATA_W-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    prod_d  = {sum, lo_q[DATA_W-1:1]};
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_FIN);
    assign prod = prod_q;

endmodule

// File: rtl/conv_mac_seq.sv
// Sequential MAC: wraps the shift-add multiplier with a wide
// accumulator, synchronous clear and a sticky overflow flag.
module conv_mac_seq
    import conv_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int ACC_W  = CONV_ACC_W,
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                accum,
    input  logic                clear_acc,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] prod,
    output logic [ACC_W-1:0]    acc,
    output logic                acc_ovf
);

    localparam logic SGN = (SIGNED != 0);

    logic             accum_q, accum_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] add_v;
    logic [ACC_W:0]   sum;
    logic             ovf_now;

    seq_mult_core #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .prod  (prod)
    );

    always_comb begin
        accum_d = (start && !busy) ? accum : accum_q;
    end

    // Clear takes effect before a coincident accumulate.
    always_comb begin
        base  = clear_acc ? '0 : acc_q;
        add_v = ACC_W'(conv_ext(32'(prod), 2 * DATA_W, SGN));
        sum   = {1'b0, base} + {1'b0, add_v};
        if (SGN) begin
            ovf_now = (base[ACC_W-1] == add_v[ACC_W-1]) &&
                      (sum[ACC_W-1] != base[ACC_W-1]);
        end else begin
            ovf_now = sum[ACC_W];
        end
        acc_d     = base;
        acc_ovf_d = clear_acc ? 1'b0 : acc_ovf_q;
        if (done && accum_q) begin
            acc_d     = sum[ACC_W-1:0];
            acc_ovf_d = acc_ovf_d | ovf_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accum_q   <= 1'b0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            accum_q   <= accum_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

    assign acc     = acc_q;
    assign acc_ovf = acc_ovf_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Scoreboard bench: a signed and an unsigned MAC share one stimulus
// stream; products and accumulators are predicted with integer math.
module tb_conv_mac_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       accum = 1'b0;
    logic       clear_acc = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    logic       busy_s, done_s, ovf_s;
    logic [7:0] prod_s, acc_s;
    logic       busy_u, done_u, ovf_u;
    logic [7:0] prod_u, acc_u;

    conv_mac_seq #(.DATA_W(4), .ACC_W(8), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum),
        .clear_acc(clear_acc), .a(a), .b(b), .busy(busy_s),
        .done(done_s), .prod(prod_s), .acc(acc_s), .acc_ovf(ovf_s)
    );

    conv_mac_seq #(.DATA_W(4), .ACC_W(8), .SIGNED(0)) u_u (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum),
        .clear_acc(clear_acc), .a(a), .b(b), .busy(busy_u),
        .done(done_u), .prod(prod_u), .acc(acc_u), .acc_ovf(ovf_u)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ps;
        logic [7:0] pu;
        int         lat;
        bit         acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    time  last_start = 0;
    time  t1;

    logic [7:0] m_acc_s = '0;
    logic [7:0] m_acc_u = '0;
    bit         m_ovf_s = 0;
    bit         m_ovf_u = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int sx8(input logic [7:0] v);
        return v[7] ? int'(v) - 256 : int'(v);
    endfunction

    task automatic model_acc(input bit do_acc, input bit clr,
                             input logic [7:0] ps, input logic [7:0] pu);
        int bs, bu, ss, su;
        bs = clr ? 0 : sx8(m_acc_s);
        bu = clr ? 0 : int'(m_acc_u);
        if (clr) begin
            m_ovf_s = 0;
            m_ovf_u = 0;
            m_acc_s = '0;
            m_acc_u = '0;
        end
        if (do_acc) begin
            ss = bs + sx8(ps);
            su = bu + int'(pu);
            if (ss > 127 || ss < -128) m_ovf_s = 1;
            if (su > 255) m_ovf_u = 1;
            m_acc_s = 8'(ss);
            m_acc_u = 8'(su);
        end
    endtask

    task automatic chk_acc(input string tag);
        chk({tag, "_acc_s"}, acc_s, m_acc_s);
        chk({tag, "_acc_u"}, acc_u, m_acc_u);
        chk({tag, "_ovf_s"}, ovf_s, m_ovf_s);
        chk({tag, "_ovf_u"}, ovf_u, m_ovf_u);
    endtask

    // Called and returns at a negedge with the DUT idle.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_,
                          input bit tacc, input bit clr_fin,
                          input bit poke);
        exp_t e;
        bit   seen;
        e.ps  = 8'(sx4(ta) * sx4(tb_));
        e.pu  = 8'(int'(ta) * int'(tb_));
        e.lat = (ta == 0 || tb_ == 0) ? 1 : 5;
        e.acc = tacc;
        a = ta;
        b = tb_;
        accum = tacc;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        last_start = $time;
        #1;
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        accum = 1'($urandom);
        seen = 0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            start = (poke && n == 2);
            if (done_s) begin
                seen = 1;
                e = sb.pop_front();
                chk("latency", n, e.lat);
                chk("prod_s", prod_s, e.ps);
                chk("prod_u", prod_u, e.pu);
                chk("done_u", done_u, 1);
                chk("busy_fin", busy_s, 1);
                clear_acc = clr_fin;
                model_acc(e.acc, clr_fin, e.ps, e.pu);
            end else begin
                chk("busy_run", busy_s, 1);
            end
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        clear_acc = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_acc("post");
        chk("done_low", done_s, 0);
        chk("busy_idle", busy_s, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_prod", prod_s, 0);
        chk("rst_acc", acc_s, 0);
        chk("rst_ovf", ovf_s, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd3, 4'hF, 0, 0, 0);
        run_op(4'h8, 4'h8, 0, 0, 0);
        t1 = last_start;
        run_op(4'h7, 4'h8, 0, 0, 0);
        chk("throughput", 32'((last_start - t1) / 10), 6);
        run_op(4'hF, 4'hF, 0, 0, 0);
        run_op(4'h0, 4'h5, 0, 0, 0);
        run_op(4'h6, 4'h2, 0, 0, 0);

        repeat (3) run_op(4'h7, 4'h7, 1, 0, 0);
        chk("wrap_acc", acc_s, 8'h93);
        chk("wrap_ovf", ovf_s, 1);
        run_op(4'h7, 4'h7, 1, 1, 0);
        chk("clr_acc", acc_s, 8'd49);

        run_op(4'h2, 4'h3, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ignored_start", done_s, 0);
        end

        a = 4'd5;
        b = 4'd3;
        accum = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_s, 0);
        chk("abort_done", done_s, 0);
        chk("abort_prod", prod_s, 0);
        m_acc_s = '0;
        m_acc_u = '0;
        m_ovf_s = 0;
        m_ovf_u = 0;
        chk_acc("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", done_s, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'd5, 4'd3, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
